// File: rtl/encrypt_display_if.sv
// encrypt_display_if: control and decoder-facing signals of the encrypt display controller.
interface encrypt_display_if;
    logic        clear;
    logic        load;
    logic [15:0] code_in;
    logic        reveal_req;
    logic [1:0]  reveal_sel;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic [3:0]  encrypt_on;
    logic [2:0]  reveals_left;
    logic [1:0]  state_o;
    logic        load_err;
    logic        reveal_deny;
    modport master (
        output clear, load, code_in, reveal_req, reveal_sel,
        input  digit0, digit1, digit2, digit3, encrypt_on, reveals_left, state_o, load_err, reveal_deny
    );
    modport slave (
        input  clear, load, code_in, reveal_req, reveal_sel,
        output digit0, digit1, digit2, digit3, encrypt_on, reveals_left, state_o, load_err, reveal_deny
    );
endinterface

// File: rtl/encrypt_display_ctrl.sv
// encrypt_display_ctrl: holds a 4-digit BCD code and sequences plain show, full encryption
// and a limited number of timed single-digit reveals for four seven-segment decoders.
module encrypt_display_ctrl #(
    parameter int SHOW_CYCLES   = 50_000_000,
    parameter int REVEAL_CYCLES = 25_000_000,
    parameter int MAX_REVEALS   = 3,
    parameter int TIMER_W       = 26
) (
    input logic              clk,
    input logic              rst,
    encrypt_display_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, SHOW = 2'b01, HIDDEN = 2'b10, REVEAL = 2'b11} state_t;
    state_t st, st_nx;
    logic [15:0] code, code_nx;
    logic [3:0] enc, enc_nx;
    logic [2:0] left, left_nx;
    logic [TIMER_W-1:0] tmr, tmr_nx;
    logic err, err_nx, deny, deny_nx, valid, expire, timed;
    assign valid = bus.code_in[3:0] <= 4'd9 && bus.code_in[7:4] <= 4'd9 &&
                   bus.code_in[11:8] <= 4'd9 && bus.code_in[15:12] <= 4'd9;
    assign expire = tmr == '0;
    assign timed = st == SHOW || st == REVEAL;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
            code <= '0;
            enc <= '0;
            left <= 3'(MAX_REVEALS);
            tmr <= '0;
            err <= 1'b0;
            deny <= 1'b0;
        end else begin
            st <= st_nx;
            code <= code_nx;
            enc <= enc_nx;
            left <= left_nx;
            tmr <= tmr_nx;
            err <= err_nx;
            deny <= deny_nx;
        end
    end
    always_comb begin
        st_nx = st;
        if (bus.clear) st_nx = IDLE;
        else if (bus.load) st_nx = valid ? SHOW : st;
        else if (st == HIDDEN && bus.reveal_req && left != '0) st_nx = REVEAL;
        else if (timed && expire) st_nx = HIDDEN;
    end
    // A rejected load consumes the cycle: nothing else advances, including the timer.
    always_comb begin
        code_nx = code;
        enc_nx = enc;
        left_nx = left;
        tmr_nx = tmr;
        err_nx = 1'b0;
        deny_nx = 1'b0;
        if (bus.clear) begin
            code_nx = '0;
            enc_nx = '0;
            left_nx = 3'(MAX_REVEALS);
            tmr_nx = '0;
        end else if (bus.load) begin
            err_nx = !valid;
            code_nx = valid ? bus.code_in : code;
            enc_nx = valid ? 4'b0000 : enc;
            left_nx = valid ? 3'(MAX_REVEALS) : left;
            tmr_nx = valid ? TIMER_W'(SHOW_CYCLES - 1) : tmr;
        end else if (st == HIDDEN && bus.reveal_req) begin
            deny_nx = left == '0;
            enc_nx = left != '0 ? ~(4'b0001 << bus.reveal_sel) : enc;
            left_nx = left != '0 ? left - 3'd1 : left;
            tmr_nx = left != '0 ? TIMER_W'(REVEAL_CYCLES - 1) : tmr;
        end else if (timed) begin
            enc_nx = expire ? 4'b1111 : enc;
            tmr_nx = expire ? '0 : tmr - 1'b1;
        end
    end
    assign bus.digit0 = code[3:0];
    assign bus.digit1 = code[7:4];
    assign bus.digit2 = code[11:8];
    assign bus.digit3 = code[15:12];
    assign bus.encrypt_on = enc;
    assign bus.reveals_left = left;
    assign bus.state_o = st;
    assign bus.load_err = err;
    assign bus.reveal_deny = deny;
endmodule

// File: tb/tb_encrypt_display_ctrl.sv
// tb_encrypt_display_ctrl: directed checks of show/hide/reveal sequencing, load rejection,
// clear priority and asynchronous reset with short timer parameters.
module tb_encrypt_display_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;
    encrypt_display_if bus ();
    encrypt_display_ctrl #(.SHOW_CYCLES(4), .REVEAL_CYCLES(3), .MAX_REVEALS(2), .TIMER_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic int digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction
    initial begin
        bus.clear = 0; bus.load = 0; bus.code_in = '0; bus.reveal_req = 0; bus.reveal_sel = '0;
        step(); step();
        chk("rst_state", bus.state_o, 0);
        chk("rst_left", bus.reveals_left, 2);
        rst = 1'b1;
        step();
        chk("idle_digits", digits(), 16'h0000);
        chk("idle_enc", bus.encrypt_on, 4'b0000);
        chk("idle_state", bus.state_o, 0);
        chk("idle_left", bus.reveals_left, 2);
        bus.load = 1; bus.code_in = 16'h9173;
        step();
        bus.load = 0;
        chk("load_digits", digits(), 16'h9173);
        chk("load_enc", bus.encrypt_on, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("show_state%0d", i), bus.state_o, 1);
            if (i < 3) step();
        end
        step();
        chk("hidden_state", bus.state_o, 2);
        chk("hidden_enc", bus.encrypt_on, 4'b1111);
        bus.reveal_req = 1; bus.reveal_sel = 2;
        step();
        chk("rev1_enc", bus.encrypt_on, 4'b1011);
        chk("rev1_left", bus.reveals_left, 1);
        chk("rev1_state", bus.state_o, 3);
        step();
        bus.reveal_req = 0;
        chk("rev1_ignore_state", bus.state_o, 3);
        chk("rev1_ignore_left", bus.reveals_left, 1);
        chk("rev1_ignore_deny", bus.reveal_deny, 0);
        step();
        chk("rev1_last_state", bus.state_o, 3);
        step();
        chk("rev1_end_state", bus.state_o, 2);
        chk("rev1_end_enc", bus.encrypt_on, 4'b1111);
        bus.reveal_req = 1; bus.reveal_sel = 0;
        step();
        bus.reveal_req = 0;
        chk("rev2_enc", bus.encrypt_on, 4'b1110);
        chk("rev2_left", bus.reveals_left, 0);
        step(); step(); step();
        chk("rev2_end_state", bus.state_o, 2);
        bus.reveal_req = 1; bus.reveal_sel = 1;
        step();
        bus.reveal_req = 0;
        chk("deny_pulse", bus.reveal_deny, 1);
        chk("deny_enc", bus.encrypt_on, 4'b1111);
        chk("deny_state", bus.state_o, 2);
        chk("deny_left", bus.reveals_left, 0);
        step();
        chk("deny_drop", bus.reveal_deny, 0);
        bus.load = 1; bus.code_in = 16'h12A4;
        step();
        bus.load = 0;
        chk("err_pulse", bus.load_err, 1);
        chk("err_digits", digits(), 16'h9173);
        chk("err_state", bus.state_o, 2);
        step();
        chk("err_drop", bus.load_err, 0);
        bus.load = 1; bus.code_in = 16'h0005;
        step();
        bus.load = 0;
        chk("reload_state", bus.state_o, 1);
        chk("reload_left", bus.reveals_left, 2);
        chk("reload_digits", digits(), 16'h0005);
        chk("reload_enc", bus.encrypt_on, 4'b0000);
        step(); step(); step(); step();
        chk("reload_hidden", bus.state_o, 2);
        bus.reveal_req = 1; bus.reveal_sel = 3;
        step();
        bus.reveal_req = 0;
        chk("rev3_enc", bus.encrypt_on, 4'b0111);
        chk("rev3_left", bus.reveals_left, 1);
        bus.clear = 1; bus.load = 1; bus.code_in = 16'h4444;
        step();
        bus.clear = 0; bus.load = 0;
        chk("clr_state", bus.state_o, 0);
        chk("clr_digits", digits(), 16'h0000);
        chk("clr_enc", bus.encrypt_on, 4'b0000);
        chk("clr_left", bus.reveals_left, 2);
        bus.load = 1; bus.code_in = 16'h8888;
        step();
        bus.load = 0;
        chk("pre_rst_state", bus.state_o, 1);
        step();
        rst = 1'b0;
        #1;
        chk("async_rst_state", bus.state_o, 0);
        chk("async_rst_digits", digits(), 16'h0000);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_state", bus.state_o, 0);
        chk("post_rst_digits", digits(), 16'h0000);
        chk("post_rst_enc", bus.encrypt_on, 4'b0000);
        chk("post_rst_left", bus.reveals_left, 2);
        chk("post_rst_err", bus.load_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
